hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised stall unit for the 5-stage MIPS pipeline. Sits beside the ID stage and drives PC write enable, IF/ID write enable and the ID/EX bubble.
- Replaces fixed lw-use and branch-in-ID comparisons with a per-register readiness scoreboard.
- Latencies per operation class (ALU, load, multi-cycle MUL) are parameters, so the same block covers deeper memory or multiplier stages.
- Adds a saturating stall-cycle performance counter.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is never tracked.
- REG_ADDR_W, 5, register address width (log2 NUM_REGS).
- ALU_LAT, 1, cycles after issue before an ALU result is forwardable to an ID-stage consumer.
- LOAD_LAT, 2, same for loads.
- MUL_LAT, 4, same for MUL/DIV class.
- PERF_W, 32, stall counter width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_ADDR_W  source A.
- id_rt  in  REG_ADDR_W  source B.
- id_rs_used  in  1  source A is read.
- id_rt_used  in  1  source B is read.
- id_is_branch  in  1  beq/bne: operands consumed in ID.
- id_wr_en  in  1  instruction writes a register.
- id_dst  in  REG_ADDR_W  destination register.
- id_op_class  in  2  0 NONE, 1 ALU, 2 LOAD, 3 MUL.
- flush  in  1  squash the ID instruction (taken branch/jump).
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID update enable.
- nop  out  1  insert a bubble into ID/EX.
- stall_cnt  out  PERF_W  cycles with hazard stall asserted, saturating.

Behaviour:
- State:
  - cnt[r] for r = 1..NUM_REGS-1, width clog2(max(ALU_LAT, LOAD_LAT, MUL_LAT)+1).
  - cnt[0] is hardwired 0.
- Reset (asynchronous, rst_n low):
  - All cnt = 0 and stall_cnt = 0.
  - Outputs then read pc_write=1, if_id_write=1, nop=0.
  - Reset mid-stall clears all pending hazards immediately.
- Hazard evaluation is combinational on the current cnt values and ID inputs:
  - need(src) = used && src != 0 && (id_is_branch ? cnt[src] > 0 : cnt[src] > 1).
  - hazard = id_valid && !flush && (need(rs) || need(rt)).
- Outputs:
  - hazard=1: pc_write=0, if_id_write=0, nop=1.
  - flush=1: pc_write=1, if_id_write=1, nop=1. Flush overrides hazard.
  - Otherwise: pc_write=1, if_id_write=1, nop=0.
- Issue: issue = id_valid && !hazard && !flush && id_wr_en && id_dst != 0 && id_op_class != NONE.
- Counter update on each rising edge:
  - For r == id_dst with issue: cnt[r] = latency of the class (ALU_LAT / LOAD_LAT / MUL_LAT).
  - Otherwise: cnt[r] = cnt[r] - 1, saturating at 0.
  - Issue and decrement on the same register: issue wins (WAW overwrite).
- Equivalence to the previous fixed scheme at default latencies:
  - lw-use: one bubble.
  - Branch after ALU: one bubble.
  - Branch after lw: two bubbles.
- stall_cnt increments on each edge where hazard=1 and saturates at all ones. Flush cycles are not counted.
- Latency parameters of 0 are legal: that class never stalls.

Decomposition:
- Package hazard_pkg:
  - op-class encoding (OP_NONE=0, OP_ALU=1, OP_LOAD=2, OP_MUL=3).
  - Function returning the latency of a class.
  - Function computing counter width from the latency parameters.
- Sub-module hazard_ready_counter: one per-register loadable saturating down counter (load, load_val, count, is_zero, gt_one), generated NUM_REGS-1 times.

Test Plan:
- Reset: rst_n low mid-stall (cnt[8]=2) -> same cycle pc_write=1, nop=0, stall_cnt=0; after release, consumer of r8 issues without stall.
- lw r8 issued (class LOAD); next cycle add using rs=8 -> exactly 1 cycle pc_write=0/if_id_write=0/nop=1, then issue; stall_cnt=1.
- add r9 (ALU); next cycle beq rs=9 -> 1 bubble. lw r10; next cycle bne rt=10 -> 2 bubbles; stall_cnt +3 total.
- MUL_LAT=4: mul r11; then a non-branch consumer of r11 -> 3 bubbles; a branch consumer instead -> 4 bubbles.
- Source r0, or id_rs_used=0 with matching address -> never stalls. flush=1 during a hazard -> nop=1, pc_write=1, no issue, stall_cnt unchanged.
- lw r12 then, 1 cycle later, add r12 issues -> cnt[12] reloaded to 1; a branch on r12 the following cycle -> 1 bubble only.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared op-class encoding and latency helpers for the ID-stage hazard scoreboard.
package hazard_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ALU  = 2'd1,
    OP_LOAD = 2'd2,
    OP_MUL  = 2'd3
  } op_class_e;

  function automatic int class_lat(op_class_e c, int alu_lat, int load_lat, int mul_lat);
    case (c)
      OP_ALU:  return alu_lat;
      OP_LOAD: return load_lat;
      OP_MUL:  return mul_lat;
      default: return 0;
    endcase
  endfunction

  // Wide enough to hold the longest latency; never narrower than one bit.
  function automatic int cnt_width(int alu_lat, int load_lat, int mul_lat);
    int m;
    m = alu_lat;
    if (load_lat > m) m = load_lat;
    if (mul_lat > m) m = mul_lat;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hazard_ready_counter.sv
// Per-register readiness counter: loads the producer latency, then counts down to zero.
module hazard_ready_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         is_zero,
  output logic         gt_one
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (load)                 cnt <= load_val;
    else if (count && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign is_zero = (cnt == '0);
  assign gt_one  = |(cnt >> 1);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage stall unit: per-register readiness scoreboard driving PC/IF-ID enables and the ID/EX bubble.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_LAT    = 1,
  parameter int LOAD_LAT   = 2,
  parameter int MUL_LAT    = 4,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic                  id_is_branch,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic [1:0]            id_op_class,
  input  logic                  flush,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  nop,
  output logic [PERF_W-1:0]     stall_cnt
);

  localparam int CW = cnt_width(ALU_LAT, LOAD_LAT, MUL_LAT);

  op_class_e           cls;
  logic [CW-1:0]       lat_val;
  logic [NUM_REGS-1:0] zero, gt1;
  logic                need_rs, need_rt, hazard, issue;

  assign cls     = op_class_e'(id_op_class);
  assign lat_val = CW'(class_lat(cls, ALU_LAT, LOAD_LAT, MUL_LAT));

  // r0 is never written, so it always reads as ready.
  assign zero[0] = 1'b1;
  assign gt1[0]  = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    hazard_ready_counter #(.W(CW)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (issue && id_dst == REG_ADDR_W'(r)),
      .load_val (lat_val),
      .count    (1'b1),
      .is_zero  (zero[r]),
      .gt_one   (gt1[r])
    );
  end

  // Branches read operands in ID, so they wait one cycle longer than EX consumers.
  assign need_rs = id_rs_used && id_rs != '0 && (id_is_branch ? !zero[id_rs] : gt1[id_rs]);
  assign need_rt = id_rt_used && id_rt != '0 && (id_is_branch ? !zero[id_rt] : gt1[id_rt]);
  assign hazard  = id_valid && !flush && (need_rs || need_rt);
  assign issue   = id_valid && !hazard && !flush && id_wr_en && id_dst != '0 && cls != OP_NONE;

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    nop         = 1'b0;
    if (flush) begin
      nop = 1'b1;
    end else if (hazard) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      nop         = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stall_cnt <= '0;
    else if (hazard && stall_cnt != '1)  stall_cnt <= stall_cnt + PERF_W'(1);
  end

endmodule
